ram_burst_ctrl: RTL and testbench

Burst requester that drives a single-port synchronous RAM: accepts read or write burst commands, sequences the RAM's write-enable, address and write-data lines, and streams read data out through a valid/ready port. It absorbs the RAM's one-cycle read latency with a two-entry output buffer so downstream backpressure never loses a word. It sits between the TPU memory controller's command logic and one RAM bank.

---
 rtl/ram_ctrl_pkg.sv | 18 +
 rtl/ram_rd_skid_fifo.sv | 62 ++++++
 rtl/ram_burst_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_ram_burst_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_ctrl_pkg.sv
// Shared types and constants for the RAM burst controller and its read buffer.
package ram_ctrl_pkg;

  // Controller states; explicit encodings keep the register layout stable.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } ram_ctrl_state_e;

  // Depth of the read-data buffer that absorbs the RAM's one-cycle read latency.
  localparam int RD_BUF_DEPTH = 2;

  // Width of the buffer occupancy count (0..RD_BUF_DEPTH).
  localparam int RD_BUF_CNT_BITS = 2;

endpackage

// File: rtl/ram_rd_skid_fifo.sv
// Two-entry read buffer. Head entry is presented combinationally; push and
// pop in the same cycle are legal at any occupancy, including full.
module ram_rd_skid_fifo
  import ram_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_in,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [RD_BUF_CNT_BITS-1:0] count,
  output logic [WIDTH-1:0]           head
);

  logic                       wr_ptr_reg;
  logic                       rd_ptr_reg;
  logic [RD_BUF_CNT_BITS-1:0] count_reg;
  logic                       do_push;
  logic                       do_pop;

  // A pop of an empty buffer is ignored; a push into a full buffer is only
  // taken when the head is leaving in the same cycle.
  assign do_pop  = pop && (count_reg != '0);
  assign do_push = push && ((count_reg != RD_BUF_CNT_BITS'(RD_BUF_DEPTH)) || do_pop);

  // One storage register per entry, written when the write pointer selects it.
  for (genvar gi = 0; gi < RD_BUF_DEPTH; gi++) begin : g_entry
    logic [WIDTH-1:0] data_reg;

    // Capture pushed data into this entry; cleared on reset so the head reads zero.
    always_ff @(posedge clk) begin
      if (rst_in) begin
        data_reg <= '0;
      end else if (do_push && (wr_ptr_reg == 1'(gi))) begin
        data_reg <= push_data;
      end
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst_in) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= ~wr_ptr_reg;
      end
      if (do_pop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
      count_reg <= count_reg + RD_BUF_CNT_BITS'(do_push) - RD_BUF_CNT_BITS'(do_pop);
    end
  end

  assign count = count_reg;
  assign head  = rd_ptr_reg ? g_entry[1].data_reg : g_entry[0].data_reg;

endmodule

// File: rtl/ram_burst_ctrl.sv
// Burst requester for one single-port synchronous RAM bank. Write bursts pass
// beats straight to the RAM; read bursts issue one address per cycle while
// buffer credit allows and stream returned words through a valid/ready port.
// Optional feature macro: RAM_BURST_RANGE_CHECK_EN (rejects bursts that would
// run past the top of the address space; otherwise addresses wrap).
module ram_burst_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int RAM_WIDTH     = 32,
  parameter int RAM_ADDR_BITS = 10,
  parameter int LEN_BITS      = 10
) (
  input  logic                     clk,
  input  logic                     rst_in,
  input  logic                     cmd_valid_in,
  output logic                     cmd_ready_out,
  input  logic                     cmd_write_in,
  input  logic [RAM_ADDR_BITS-1:0] cmd_addr_in,
  input  logic [LEN_BITS-1:0]      cmd_len_in,
  input  logic                     wr_valid_in,
  output logic                     wr_ready_out,
  input  logic [RAM_WIDTH-1:0]     wr_data_in,
  output logic                     rd_valid_out,
  input  logic                     rd_ready_in,
  output logic [RAM_WIDTH-1:0]     rd_data_out,
  output logic                     ram_we_out,
  output logic [RAM_ADDR_BITS-1:0] ram_addr_out,
  output logic [RAM_WIDTH-1:0]     ram_wdata_out,
  input  logic [RAM_WIDTH-1:0]     ram_rdata_in,
  output logic                     busy_out,
  output logic                     done_out,
  output logic                     err_out
);

  ram_ctrl_state_e            state_reg;
  ram_ctrl_state_e            state_next;
  logic [RAM_ADDR_BITS-1:0]   addr_reg;
  logic [RAM_ADDR_BITS-1:0]   addr_next;
  logic [LEN_BITS-1:0]        count_reg;
  logic [LEN_BITS-1:0]        count_next;
  logic                       inflight_reg;
  logic                       inflight_next;
  logic                       done_reg;
  logic                       done_next;
  logic                       err_reg;
  logic                       err_next;

  logic [RD_BUF_CNT_BITS-1:0] buf_count;
  logic [RAM_WIDTH-1:0]       buf_head;
  logic                       buf_push;
  logic                       buf_pop;
  logic [RD_BUF_CNT_BITS:0]   occ_after;
  logic                       credit_ok;
  logic                       issue;
  logic                       range_err;

`ifdef RAM_BURST_RANGE_CHECK_EN
  localparam int SUM_W = ((RAM_ADDR_BITS > LEN_BITS) ? RAM_ADDR_BITS : LEN_BITS) + 1;
  logic [SUM_W-1:0] end_addr;

  // Last address the burst would touch, computed without wrap.
  assign end_addr  = SUM_W'(cmd_addr_in) + SUM_W'(cmd_len_in);
  assign range_err = end_addr > SUM_W'({RAM_ADDR_BITS{1'b1}});
`else
  assign range_err = 1'b0;
`endif

  // Read buffer: returning RAM data is pushed the cycle after each issue.
  assign buf_push = inflight_reg;
  assign buf_pop  = rd_valid_out && rd_ready_in;

  ram_rd_skid_fifo #(
    .WIDTH (RAM_WIDTH)
  ) u_rd_fifo (
    .clk       (clk),
    .rst_in    (rst_in),
    .push      (buf_push),
    .push_data (ram_rdata_in),
    .pop       (buf_pop),
    .count     (buf_count),
    .head      (buf_head)
  );

  // Credit: words held plus the word in flight, less the one leaving now,
  // must leave room for another word so no push ever lands on a full buffer.
  assign occ_after = (RD_BUF_CNT_BITS + 1)'(buf_count)
                   + (RD_BUF_CNT_BITS + 1)'(inflight_reg)
                   - (RD_BUF_CNT_BITS + 1)'(buf_pop);
  assign credit_ok = occ_after < (RD_BUF_CNT_BITS + 1)'(RD_BUF_DEPTH);
  assign issue     = (state_reg == READ) && credit_ok;

  // Next-state, address/count sequencing and completion pulses.
  always_comb begin
    state_next    = state_reg;
    addr_next     = addr_reg;
    count_next    = count_reg;
    inflight_next = 1'b0;
    done_next     = 1'b0;
    err_next      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (cmd_valid_in) begin
          addr_next  = cmd_addr_in;
          count_next = cmd_len_in;
          if (range_err) begin
            done_next = 1'b1;
            err_next  = 1'b1;
          end else if (cmd_write_in) begin
            state_next = WRITE;
          end else begin
            state_next = READ;
          end
        end
      end
      WRITE: begin
        if (wr_valid_in) begin
          addr_next  = addr_reg + RAM_ADDR_BITS'(1);
          count_next = count_reg - LEN_BITS'(1);
          if (count_reg == '0) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end
      end
      READ: begin
        if (issue) begin
          inflight_next = 1'b1;
          addr_next     = addr_reg + RAM_ADDR_BITS'(1);
          count_next    = count_reg - LEN_BITS'(1);
          if (count_reg == '0) begin
            state_next = DRAIN;
          end
        end
      end
      DRAIN: begin
        // Finish on the cycle the final word is popped so done_out follows it.
        if (!inflight_reg && (buf_count == RD_BUF_CNT_BITS'(buf_pop))) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Controller state registers; reset aborts any burst without a done pulse.
  always_ff @(posedge clk) begin
    if (rst_in) begin
      state_reg    <= IDLE;
      addr_reg     <= '0;
      count_reg    <= '0;
      inflight_reg <= 1'b0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      addr_reg     <= addr_next;
      count_reg    <= count_next;
      inflight_reg <= inflight_next;
      done_reg     <= done_next;
      err_reg      <= err_next;
    end
  end

  assign cmd_ready_out = (state_reg == IDLE);
  assign wr_ready_out  = (state_reg == WRITE);
  assign busy_out      = (state_reg != IDLE);
  assign done_out      = done_reg;
  assign err_out       = err_reg;

  assign rd_valid_out  = (buf_count != '0);
  assign rd_data_out   = buf_head;

  // Write enable is combinational from the beat valid but never during reset.
  assign ram_we_out    = (state_reg == WRITE) && wr_valid_in && !rst_in;
  assign ram_addr_out  = addr_reg;
  assign ram_wdata_out = wr_data_in;

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Self-checking bench for ram_burst_ctrl with a behavioural synchronous RAM
// and scoreboard queues for expected RAM writes and expected read words.
module tb_ram_burst_ctrl;

  logic        clk;
  logic        rst_in;
  logic        cmd_valid_in;
  logic        cmd_ready_out;
  logic        cmd_write_in;
  logic [9:0]  cmd_addr_in;
  logic [9:0]  cmd_len_in;
  logic        wr_valid_in;
  logic        wr_ready_out;
  logic [31:0] wr_data_in;
  logic        rd_valid_out;
  logic        rd_ready_in;
  logic [31:0] rd_data_out;
  logic        ram_we_out;
  logic [9:0]  ram_addr_out;
  logic [31:0] ram_wdata_out;
  logic [31:0] ram_rdata_in;
  logic        busy_out;
  logic        done_out;
  logic        err_out;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int last_pop_cyc = -1;

  logic [41:0] exp_wr_q [$];
  logic [31:0] exp_rd_q [$];
  logic [31:0] ram_mem [1024];
  logic [31:0] ref_mem [1024];

  ram_burst_ctrl #(
    .RAM_WIDTH     (32),
    .RAM_ADDR_BITS (10),
    .LEN_BITS      (10)
  ) dut (
    .clk           (clk),
    .rst_in        (rst_in),
    .cmd_valid_in  (cmd_valid_in),
    .cmd_ready_out (cmd_ready_out),
    .cmd_write_in  (cmd_write_in),
    .cmd_addr_in   (cmd_addr_in),
    .cmd_len_in    (cmd_len_in),
    .wr_valid_in   (wr_valid_in),
    .wr_ready_out  (wr_ready_out),
    .wr_data_in    (wr_data_in),
    .rd_valid_out  (rd_valid_out),
    .rd_ready_in   (rd_ready_in),
    .rd_data_out   (rd_data_out),
    .ram_we_out    (ram_we_out),
    .ram_addr_out  (ram_addr_out),
    .ram_wdata_out (ram_wdata_out),
    .ram_rdata_in  (ram_rdata_in),
    .busy_out      (busy_out),
    .done_out      (done_out),
    .err_out       (err_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural single-port RAM with one-cycle registered read.
  always @(posedge clk) begin
    if (ram_we_out) ram_mem[ram_addr_out] <= ram_wdata_out;
    ram_rdata_in <= ram_mem[ram_addr_out];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Monitor: every RAM write and every read pop is matched against the scoreboard.
  always @(negedge clk) begin
    logic [41:0] e;
    if (ram_we_out) begin
      if (exp_wr_q.size() == 0) begin
        check("wr_unexpected", 1, 0);
      end else begin
        e = exp_wr_q.pop_front();
        $display("ram write addr=0x%03h data=0x%08h", ram_addr_out, ram_wdata_out);
        check("wr_addr", ram_addr_out, e[41:32]);
        check("wr_data", ram_wdata_out, e[31:0]);
      end
    end
    if (rd_valid_out && rd_ready_in) begin
      if (exp_rd_q.size() == 0) begin
        check("rd_unexpected", 1, 0);
      end else begin
        $display("read pop data=0x%08h", rd_data_out);
        check("rd_data", rd_data_out, exp_rd_q.pop_front());
      end
      last_pop_cyc = cyc;
    end
  end

  // Write burst; pat[k] gives wr_valid_in for the k-th cycle in WRITE.
  task automatic do_write(input logic [9:0] addr, input logic [9:0] len,
                          input logic [15:0] pat, input logic [31:0] base);
    logic [9:0] a;
    int beats;
    int k;
    a = addr;
    cmd_valid_in = 1'b1; cmd_write_in = 1'b1; cmd_addr_in = addr; cmd_len_in = len;
    @(negedge clk);
    check("wr_cmd_ready", cmd_ready_out, 1);
    @(posedge clk); #1;
    cmd_valid_in = 1'b0;
    beats = 0;
    k = 0;
    while (beats <= int'(len) && k < 100) begin
      wr_valid_in = (k < 16) ? pat[k] : 1'b1;
      if (wr_valid_in) begin
        wr_data_in = base + 32'(beats);
        exp_wr_q.push_back({a, wr_data_in});
        ref_mem[a] = wr_data_in;
      end
      @(negedge clk);
      check("wr_ready", wr_ready_out, 1);
      check("wr_done_early", done_out, 0);
      @(posedge clk); #1;
      if (wr_valid_in) begin
        beats++;
        a = a + 10'd1;
      end
      k++;
    end
    wr_valid_in = 1'b0;
    @(negedge clk);
    check("wr_done", done_out, 1);
    check("wr_err", err_out, 0);
    check("wr_q_empty", exp_wr_q.size(), 0);
    @(posedge clk); #1;
    check("wr_done_pulse", done_out, 0);
  endtask

  // Read burst; toggle alternates rd_ready_in, chk_first checks first-word latency.
  task automatic do_read(input logic [9:0] addr, input logic [9:0] len,
                         input bit toggle, input bit chk_first);
    logic [9:0] a;
    bit got_done;
    int done_cyc;
    a = addr;
    for (int i = 0; i <= int'(len); i++) begin
      exp_rd_q.push_back(ref_mem[a]);
      a = a + 10'd1;
    end
    rd_ready_in  = toggle ? 1'b0 : 1'b1;
    cmd_valid_in = 1'b1; cmd_write_in = 1'b0; cmd_addr_in = addr; cmd_len_in = len;
    @(negedge clk);
    check("rd_cmd_ready", cmd_ready_out, 1);
    @(posedge clk); #1;
    cmd_valid_in = 1'b0;
    got_done = 1'b0;
    done_cyc = -1;
    for (int k = 1; k < 400 && !got_done; k++) begin
      rd_ready_in = toggle ? ((k % 2) == 1) : 1'b1;
      @(negedge clk);
      if (chk_first && k <= 3) check("rd_first_valid", rd_valid_out, (k == 3));
      check("rd_no_we", ram_we_out, 0);
      if (done_out) begin
        got_done = 1'b1;
        done_cyc = cyc;
      end
      @(posedge clk); #1;
    end
    rd_ready_in = 1'b0;
    check("rd_done_seen", got_done, 1);
    check("rd_done_timing", done_cyc, last_pop_cyc + 1);
    check("rd_q_empty", exp_rd_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_in = 1'b1;
    cmd_valid_in = 1'b0; cmd_write_in = 1'b0; cmd_addr_in = '0; cmd_len_in = '0;
    wr_valid_in = 1'b0; wr_data_in = '0; rd_ready_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    wr_valid_in = 1'b1;
    @(negedge clk);
    check("rst_we_forced", ram_we_out, 0);
    @(posedge clk); #1;
    wr_valid_in = 1'b0;
    rst_in = 1'b0;
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready_out, 1);
    check("rst_wr_ready", wr_ready_out, 0);
    check("rst_rd_valid", rd_valid_out, 0);
    check("rst_rd_data", rd_data_out, 0);
    check("rst_we", ram_we_out, 0);
    check("rst_addr", ram_addr_out, 0);
    check("rst_busy", busy_out, 0);
    check("rst_done", done_out, 0);
    check("rst_err", err_out, 0);
    @(posedge clk); #1;

`ifndef RAM_BURST_RANGE_CHECK_EN
    // Wrapping write then read-back with rd_ready held high.
    do_write(10'h3FE, 10'd3, 16'hFFFF, 32'hA0);
    do_read(10'h3FE, 10'd3, 1'b0, 1'b1);
`endif

    // Longer read with rd_ready toggling.
    do_write(10'h100, 10'd7, 16'hFFFF, 32'hB0);
    do_read(10'h100, 10'd7, 1'b1, 1'b0);

    // Write with gaps in wr_valid_in (1,0,0,1,1), then read back.
    do_write(10'h200, 10'd2, 16'hFFF9, 32'hC0);
    do_read(10'h200, 10'd2, 1'b0, 1'b1);

    // Reset mid-read with the buffer full.
    rd_ready_in  = 1'b0;
    cmd_valid_in = 1'b1; cmd_write_in = 1'b0; cmd_addr_in = 10'h100; cmd_len_in = 10'd7;
    @(posedge clk); #1;
    cmd_valid_in = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_in = 1'b1;
    @(negedge clk);
    check("mid_rd_valid", rd_valid_out, 1);
    check("mid_busy", busy_out, 1);
    check("mid_cmd_ready", cmd_ready_out, 0);
    check("mid_we", ram_we_out, 0);
    @(posedge clk); #1;
    rst_in = 1'b0;
    @(negedge clk);
    check("abort_rd_valid", rd_valid_out, 0);
    check("abort_rd_data", rd_data_out, 0);
    check("abort_cmd_ready", cmd_ready_out, 1);
    check("abort_busy", busy_out, 0);
    check("abort_done", done_out, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_no_done", done_out, 0);
      check("abort_no_we", ram_we_out, 0);
    end
    @(posedge clk); #1;

`ifdef RAM_BURST_RANGE_CHECK_EN
    // Out-of-range write: accepted, no RAM access, err and done together.
    cmd_valid_in = 1'b1; cmd_write_in = 1'b1; cmd_addr_in = 10'h3FE; cmd_len_in = 10'd3;
    wr_valid_in  = 1'b1; wr_data_in = 32'hDEAD;
    @(negedge clk);
    check("rng_cmd_ready", cmd_ready_out, 1);
    check("rng_we0", ram_we_out, 0);
    @(posedge clk); #1;
    cmd_valid_in = 1'b0;
    @(negedge clk);
    check("rng_err", err_out, 1);
    check("rng_done", done_out, 1);
    check("rng_wr_ready", wr_ready_out, 0);
    check("rng_we1", ram_we_out, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("rng_err_pulse", err_out, 0);
    check("rng_we2", ram_we_out, 0);
    wr_valid_in = 1'b0;
    @(posedge clk); #1;
`endif

    check("end_wr_q_empty", exp_wr_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
